// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop synchroniser, mid-bit sampling and one-cycle result pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches on o_rx_parity_err.
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_in,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_busy,
    output logic       o_rx_frame_err,
    output logic       o_rx_parity_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t         r_state, w_next;
    logic [1:0]     r_sync;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_idx;
    logic [7:0]     r_shift;
    logic [7:0]     r_data;
    logic           r_valid, r_ferr;
    logic           w_rx_s, w_tick, w_stop_smp, w_set_valid, w_set_ferr, w_par_ok;

    assign w_rx_s         = r_sync[1];
    assign o_rx_data      = r_data;
    assign o_rx_valid     = r_valid;
    assign o_rx_frame_err = r_ferr;
    assign o_rx_busy      = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sync  <= {r_sync[0], i_rx_in};
            r_cnt   <= (r_state == IDLE || r_state == WAIT_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
            if (r_state == DATA && w_tick) begin
                r_shift[r_idx] <= w_rx_s;
                r_idx          <= r_idx + 1'b1;
            end else if (r_state == START) begin
                r_idx <= '0;
            end
            if (w_set_valid)
                r_data <= r_shift;
            r_valid <= w_set_valid;
            r_ferr  <= w_set_ferr;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_rx_s ? IDLE : START;
            START:     w_next = w_tick ? (w_rx_s ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
            DATA:      w_next = (w_tick && r_idx == 3'd7) ? PARITY : DATA;
            PARITY:    w_next = w_tick ? STOP : PARITY;
`else
            DATA:      w_next = (w_tick && r_idx == 3'd7) ? STOP : DATA;
`endif
            STOP:      w_next = w_tick ? (w_rx_s ? IDLE : WAIT_IDLE) : STOP;
            WAIT_IDLE: w_next = w_rx_s ? IDLE : WAIT_IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // START samples at half a bit, every later state at a full bit period
    always_comb begin
        w_tick      = (r_state == START) ? (r_cnt == HALF)
                    : ((r_state == DATA || r_state == PARITY || r_state == STOP) && r_cnt == LAST);
        w_stop_smp  = (r_state == STOP) && w_tick;
        w_set_valid = w_stop_smp && w_rx_s && w_par_ok;
        w_set_ferr  = w_stop_smp && !w_rx_s;
    end

`ifdef UART_RX_PARITY_EN
    logic r_par, r_perr;

    assign w_par_ok        = (r_par == ^r_shift);
    assign o_rx_parity_err = r_perr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (r_state == PARITY && w_tick)
                r_par <= w_rx_s;
            r_perr <= w_stop_smp && w_rx_s && !w_par_ok;
        end
    end
`else
    assign w_par_ok        = 1'b1;
    assign o_rx_parity_err = 1'b0;
`endif

endmodule
